sipo_deserializer: RTL
======================

SIPO_DESERIALIZER -- requirements
Module: sipo_deserializer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named as the codebase does: clk and reset.
REQ-002 The block SHALL have parameter WIDTH, default 4: word width in bits; legal range 2..16.
REQ-003 The block SHALL have parameter MSB_FIRST, default 1: 1 = first received bit lands in parallel_out[WIDTH-1]; 0 = first bit lands in parallel_out[0].
REQ-004 Port clk: input, 1 bit, rising-edge clock for all state.
REQ-005 Port reset: input, 1 bit, synchronous active-high reset.
REQ-006 Port serial_in: input, 1 bit, serial data bit, sampled only when serial_valid=1.
REQ-007 Port serial_valid: input, 1 bit, qualifies serial_in for the current cycle.
REQ-008 Port frame_start: input, 1 bit, marks the current valid bit as bit 0 of a new word; ignored when serial_valid=0.
REQ-009 Port out_ready: input, 1 bit, downstream accepts parallel_out this cycle (drives the downstream PIPO load).
REQ-010 Port overrun_clr: input, 1 bit, clears the sticky overrun flag.
REQ-011 Port parallel_out: output, WIDTH bits, registered assembled word.
REQ-012 Port out_valid: output, 1 bit, parallel_out holds an unconsumed word.
REQ-013 Port bit_count: output, clog2(WIDTH) bits, number of bits of the partial word already captured.
REQ-014 Port overrun: output, 1 bit, sticky flag set when a completed word is dropped.

Function
REQ-015 Shifting SHALL occur only on edges where serial_valid=1: MSB_FIRST=1 shifts left, inserting serial_in at bit 0; MSB_FIRST=0 shifts right, inserting serial_in at bit WIDTH-1.
REQ-016 bit_count SHALL increment by 1 per valid bit and wrap from WIDTH-1 to 0 on the edge that captures the last bit of a word.
REQ-017 With serial_valid=1 and frame_start=1, the block SHALL discard any partial word, treat serial_in as bit 0 and set bit_count to 1, with no overrun or out_valid side effects.
REQ-018 Word completion SHALL be the edge where serial_valid=1 and bit_count=WIDTH-1 (and frame_start=0); the assembled word (shift contents plus this bit) is the candidate word.
REQ-019 The candidate word SHALL be loaded into parallel_out, with out_valid=1, on the completion edge if out_valid=0 or (out_valid=1 and out_ready=1) at that edge.
REQ-020 Latency: parallel_out and out_valid SHALL be visible in the cycle immediately after the edge that samples the last bit.
REQ-021 A transfer SHALL occur on any edge with out_valid=1 and out_ready=1; out_valid SHALL then be 0 the next cycle unless REQ-019 loads a new word on the same edge, in which case out_valid stays 1 with the new word.
REQ-022 While out_valid=1 and no transfer occurs, parallel_out SHALL be held stable.
REQ-023 out_ready while out_valid=0 SHALL have no effect.
REQ-024 If a word completes while out_valid=1 and out_ready=0, the candidate word SHALL be dropped, parallel_out retained, and overrun set to 1 on that edge.
REQ-025 overrun SHALL stay 1 until an edge with overrun_clr=1; if set and clear conditions coincide, set SHALL win.
REQ-026 Gaps (serial_valid=0) SHALL leave the shift register, bit_count, parallel_out, out_valid and overrun unchanged, except for the transfer in REQ-021.
REQ-027 Back-to-back words with out_ready held at 1 SHALL sustain one word per WIDTH valid bits with no loss.

Reset
REQ-028 On an edge with reset=1, the block SHALL set parallel_out=0, out_valid=0, bit_count=0, overrun=0 and clear the shift register; reset SHALL take priority over all other inputs.
REQ-029 Reset mid-word SHALL discard the partial word; the first valid bit after reset SHALL be bit 0.

Verification (WIDTH=4, MSB_FIRST=1)
REQ-030 Basic: valid bits 1,1,0,1 on consecutive cycles with out_ready=0 -> next cycle parallel_out=4'b1101, out_valid=1, bit_count=0, overrun=0.
REQ-031 Gaps and handshake: bits 1,0,1,0 with serial_valid low for 2 cycles between each bit -> parallel_out=4'b1010; then out_ready=1 for one cycle -> out_valid=0 the following cycle.
REQ-032 Overrun: word 4'b1101 held with out_ready=0, then a second word 0,0,1,1 -> parallel_out stays 4'b1101, overrun=1; overrun_clr pulse -> overrun=0.
REQ-033 Resync: bits 1,1 then frame_start=1 with bit 0, followed by 1,1,0 -> parallel_out=4'b0110.
REQ-034 Reset mid-word: bits 1,1,1, then reset for one cycle, then 0,1,0,1 -> parallel_out=4'b0101, with all outputs 0 in the cycle after reset.
REQ-035 Streaming: out_ready=1 constantly; bits for 4'b1100 then 4'b0011 back-to-back -> out_valid=1 for one cycle per word, both words observed, overrun=0.

Source files
------------

// File: rtl/sipo_deserializer.sv
// sipo_deserializer: serial-to-parallel word assembler with valid/ready output and sticky overrun flag
module sipo_deserializer #(
  parameter int WIDTH = 4,
  parameter bit MSB_FIRST = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       serial_in,
  input  logic                       serial_valid,
  input  logic                       frame_start,
  input  logic                       out_ready,
  input  logic                       overrun_clr,
  output logic [WIDTH-1:0]           parallel_out,
  output logic                       out_valid,
  output logic [$clog2(WIDTH)-1:0]   bit_count,
  output logic                       overrun
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] last_idx = CW'(WIDTH - 1);
  logic [WIDTH-1:0] sr, shifted, fresh;
  logic done;
  always_comb begin
    shifted = MSB_FIRST ? {sr[WIDTH-2:0], serial_in} : {serial_in, sr[WIDTH-1:1]};
    fresh = MSB_FIRST ? {{(WIDTH-1){1'b0}}, serial_in} : {serial_in, {(WIDTH-1){1'b0}}};
    done = serial_valid && !frame_start && bit_count == last_idx;
  end
  // overrun clear is written before set so a coincident set wins
  always_ff @(posedge clk) begin
    if (reset) begin
      sr <= '0;
      parallel_out <= '0;
      out_valid <= 1'b0;
      bit_count <= '0;
      overrun <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (overrun_clr) overrun <= 1'b0;
      if (serial_valid) begin
        sr <= frame_start ? fresh : shifted;
        bit_count <= frame_start ? CW'(1) : done ? '0 : bit_count + CW'(1);
      end
      if (done && (!out_valid || out_ready)) begin
        parallel_out <= shifted;
        out_valid <= 1'b1;
      end
      if (done && out_valid && !out_ready) overrun <= 1'b1;
    end
  end
endmodule
